axi_master128: RTL

Single-outstanding AXI (AXI3-style, with WID) 128-bit burst initiator. It turns local read/write commands into INCR bursts and streams data between local ready/valid ports and the AXI R/W channels. It reports one completion per command, carrying the aggregated response. It is the initiator counterpart of the 128-bit AXI-to-SRAM slave and drives a `_s0`-style slave port directly.

---
 rtl/axi_master128.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_master128.sv
// axi_master128: single-outstanding 128-bit AXI3 burst initiator.
// Local read/write commands become INCR bursts. Data streams between the local
// ready/valid ports and the AXI R/W channels with no buffering. One completion
// is reported per command, carrying the aggregated response.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command, beat counter held at zero
// AR    | read address presented, waiting for arready_m0
// R     | read beats passed through to rd_*, until the rlast_m0 handshake
// AW    | write address presented, waiting for awready_m0
// W     | write beats passed through from wr_*, until the wlast_m0 handshake
// B     | waiting for the write response
// DONE  | completion presented on done_*, waiting for done_ready

module axi_master128 #(
   parameter logic [1:0] BURST = 2'b01,
   parameter logic [3:0] CACHE = 4'b0000,
   parameter logic [2:0] PROT  = 3'b000
) (
   input  logic         pll_core_cpuclk,
   input  logic         pad_cpu_rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_write,
   input  logic [39:0]  cmd_addr,
   input  logic [7:0]   cmd_len,
   input  logic [7:0]   cmd_id,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [127:0] wr_data,
   input  logic [15:0]  wr_strb,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [127:0] rd_data,
   output logic         rd_last,
   output logic         done_valid,
   input  logic         done_ready,
   output logic [1:0]   done_resp,
   output logic [7:0]   done_id,
   output logic         arvalid_m0,
   input  logic         arready_m0,
   output logic [39:0]  araddr_m0,
   output logic [7:0]   arlen_m0,
   output logic [7:0]   arid_m0,
   output logic [2:0]   arsize_m0,
   output logic [1:0]   arburst_m0,
   output logic [3:0]   arcache_m0,
   output logic [2:0]   arprot_m0,
   output logic         awvalid_m0,
   input  logic         awready_m0,
   output logic [39:0]  awaddr_m0,
   output logic [7:0]   awlen_m0,
   output logic [7:0]   awid_m0,
   output logic [2:0]   awsize_m0,
   output logic [1:0]   awburst_m0,
   output logic [3:0]   awcache_m0,
   output logic [2:0]   awprot_m0,
   output logic         wvalid_m0,
   input  logic         wready_m0,
   output logic [127:0] wdata_m0,
   output logic [15:0]  wstrb_m0,
   output logic         wlast_m0,
   output logic [7:0]   wid_m0,
   input  logic         bvalid_m0,
   output logic         bready_m0,
   input  logic [7:0]   bid_m0,
   input  logic [1:0]   bresp_m0,
   input  logic         rvalid_m0,
   output logic         rready_m0,
   input  logic [127:0] rdata_m0,
   input  logic [7:0]   rid_m0,
   input  logic [1:0]   rresp_m0,
   input  logic         rlast_m0
);

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [39:0] addr_q;
   logic [7:0]  len_q;
   logic [7:0]  id_q;
   logic [7:0]  beat_q;
   logic [1:0]  resp_q;
   logic        err_q;

   assign araddr_m0  = addr_q;
   assign arlen_m0   = len_q;
   assign arid_m0    = id_q;
   assign arsize_m0  = 3'b100;
   assign arburst_m0 = BURST;
   assign arcache_m0 = CACHE;
   assign arprot_m0  = PROT;
   assign awaddr_m0  = addr_q;
   assign awlen_m0   = len_q;
   assign awid_m0    = id_q;
   assign awsize_m0  = 3'b100;
   assign awburst_m0 = BURST;
   assign awcache_m0 = CACHE;
   assign awprot_m0  = PROT;
   assign wid_m0     = id_q;
   assign done_id    = id_q;
   // A protocol error overrides whatever the slave reported.
   assign done_resp  = err_q ? 2'b10 : resp_q;

   // State register, command latch, beat counter and response aggregation.
   always_ff @(posedge pll_core_cpuclk) begin
      if (pad_cpu_rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         beat_q  <= '0;
         resp_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               beat_q <= '0;
               if (cmd_valid) begin
                  addr_q <= cmd_addr & ~40'hF;
                  len_q  <= cmd_len;
                  id_q   <= cmd_id;
                  resp_q <= '0;
                  err_q  <= 1'b0;
               end
            end
            S_R: begin
               if (rvalid_m0 && rd_ready) begin
                  beat_q <= beat_q + 8'd1;
                  if (rresp_m0 > resp_q) resp_q <= rresp_m0;
                  // Early last, missing last at the final beat, or a foreign ID.
                  if ((rid_m0 != id_q) || (rlast_m0 != (beat_q == len_q))) err_q <= 1'b1;
               end
            end
            S_W: begin
               if (wr_valid && wready_m0) beat_q <= beat_q + 8'd1;
            end
            S_B: begin
               if (bvalid_m0) begin
                  if (bresp_m0 > resp_q) resp_q <= bresp_m0;
                  if (bid_m0 != id_q) err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and handshake/pass-through outputs; everything is held low in reset.
   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      arvalid_m0 = 1'b0;
      awvalid_m0 = 1'b0;
      wvalid_m0  = 1'b0;
      wr_ready   = 1'b0;
      wdata_m0   = '0;
      wstrb_m0   = '0;
      wlast_m0   = 1'b0;
      bready_m0  = 1'b0;
      rready_m0  = 1'b0;
      rd_valid   = 1'b0;
      rd_data    = '0;
      rd_last    = 1'b0;
      done_valid = 1'b0;
      if (!pad_cpu_rst) begin
         case (state_q)
            S_IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) state_d = cmd_write ? S_AW : S_AR;
            end
            S_AR: begin
               arvalid_m0 = 1'b1;
               if (arready_m0) state_d = S_R;
            end
            S_R: begin
               rd_valid  = rvalid_m0;
               rready_m0 = rd_ready;
               rd_data   = rdata_m0;
               rd_last   = rlast_m0;
               if (rvalid_m0 && rd_ready && rlast_m0) state_d = S_DONE;
            end
            S_AW: begin
               awvalid_m0 = 1'b1;
               if (awready_m0) state_d = S_W;
            end
            S_W: begin
               wvalid_m0 = wr_valid;
               wr_ready  = wready_m0;
               wdata_m0  = wr_data;
               wstrb_m0  = wr_strb;
               wlast_m0  = (beat_q == len_q);
               if (wr_valid && wready_m0 && (beat_q == len_q)) state_d = S_B;
            end
            S_B: begin
               bready_m0 = 1'b1;
               if (bvalid_m0) state_d = S_DONE;
            end
            S_DONE: begin
               done_valid = 1'b1;
               if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule
